lsu_bank_responder: RTL and testbench
=====================================

# lsu_bank_responder

Memory-side responder for the four PE-row LSU ports. Captures the read/write request, address and write data from rows 0..3 and arbitrates per bank into a 4-bank scratchpad. Returns read data and write acknowledges on `CBG_to_LSU_bus_0..3`. Sits between the PE array and on-chip data memory; it is the responding end of the LSU request/response interface.

## Interface
Parameters:
- `DATA_W`, 32, data word width
- `ADDR_W`, 10, word address width; `addr[1:0]` selects the bank, `addr[ADDR_W-1:2]` is the row within the bank
- `NBANK`, 4, bank count (fixed; the bank select is `addr[1:0]`)
- `BANK_DEPTH`, 256, words per bank (`2^(ADDR_W-2)`)

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  reset; synchronous, active-high
- `R_request_n` (n=0..3)  in  `R_Q`=1  read strobe, one cycle
- `W_request_n`  in  `W_Q`=33  {wstrobe, wdata[31:0]}
- `LSU_addr_bus_n`  in  `A_bus`=10  word address, valid with either strobe
- `CBG_to_LSU_bus_n`  out  `C_L_bus`=34  {wack, rvalid, rdata[31:0]}

## Operation
- Each port has a one-entry pending register: {valid, we, addr, wdata}.
- A strobe on an idle port is captured into the pending register at the next edge.
- A strobe arriving while that port is still pending is ignored. The bench flags it as a protocol error: each LSU keeps at most one request outstanding and waits for `rvalid` or `wack`.
- If `R_request` and `wstrobe` are both high in the same cycle, the request is treated as a write and the read is dropped.
- Each bank has its own round-robin arbiter over the pending ports addressing that bank. Each bank grants at most one port per cycle; different banks serve in parallel.
- After a grant, that bank's pointer moves to the port after the winner.
- Granted write: the SRAM is written at the grant edge. `wack` pulses for one cycle on the next cycle and the pending register clears.
- Granted read: SRAM read at the grant edge. Next cycle, `rvalid` pulses for one cycle with `rdata`, and pending clears.
- `rdata` is held at its last value when `rvalid`=0. `wack` and `rvalid` are never high together on one port.
- Write then read of the same address from different ports, granted in consecutive cycles: the read returns the new data.

## Timing
- Reset: all pending registers clear, `CBG_to_LSU_bus_n`=0, round-robin pointers go to port 0. SRAM contents are not reset.
- A reset mid-operation drops every pending request with no response.
- Uncontended latency: strobe sampled at edge t → pending at t+1 → granted at edge t+1 → `rvalid`/`wack` high during cycle t+2 (2 cycles).
- Each lost arbitration adds exactly 1 cycle. Worst case with all four ports on one bank is 5 cycles.
- Back-to-back on one port: a new strobe is accepted in the same cycle its `rvalid`/`wack` is high. The pending register is already clear, so steady-state throughput is 1 request per 2 cycles per port.
- Address bits above the bank depth do not exist (`ADDR_W`=10 spans exactly 4×256), so no out-of-range case.

## Structure
- Package `lsu_if_pkg`: `R_Q`, `W_Q`, `A_bus`, `C_L_bus` values, field offsets (WSTROBE=32, WACK=33, RVALID=32), and the pending-entry struct. The same package is used by the PE-row LSU.
- Sub-module `rr_arbiter4`: 4-request round-robin arbiter with a pointer register and one-hot grant, instantiated once per bank.
- Banks are inferred as `DATA_W`×`BANK_DEPTH` synchronous single-port RAM arrays inside the block.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 0x005, then reads addr 0x005 → `wack` at cycle 2; `rvalid` with 0xDEADBEEF at cycle 2 after the read strobe.
- Ports 0–3 read addrs 0x000, 0x001, 0x002, 0x003 (distinct banks) in the same cycle → all four `rvalid` in the same cycle, 2 cycles later.
- Ports 0–3 read addrs 0x004, 0x008, 0x00C, 0x010 (all bank 0) in the same cycle, pointer at 0 → `rvalid` at latencies 2, 3, 4, 5 in port order 0, 1, 2, 3. Repeat → order 0, 1, 2, 3 again, since the pointer has wrapped back to 0.
- Port 1 asserts `R_request` and `wstrobe` together (wdata 0x12345678, addr 0x07F) → only `wack`. A later read returns 0x12345678.
- Port 2 read pending and stalled behind 3 contenders; `rst` high for one cycle → no `rvalid` ever appears. Outputs are 0 the cycle after reset. Memory written before reset is still readable.
- Port 3 issues a second strobe while pending → second request ignored. Exactly one response, and the bench protocol checker fires.

Source files
------------

// File: rtl/lsu_if_pkg.sv
// LSU request/response interface: bus widths, field offsets, pending entry.
package lsu_if_pkg;
  localparam int DW      = 32;
  localparam int R_Q     = 1;
  localparam int W_Q     = DW + 1;
  localparam int A_bus   = 10;
  localparam int C_L_bus = DW + 2;
  localparam int WSTROBE = 32;
  localparam int WACK    = 33;
  localparam int RVALID  = 32;
  localparam int NPORT   = 4;

  // One outstanding request per LSU port
  typedef struct packed {
    logic             valid;
    logic             we;
    logic [A_bus-1:0] addr;
    logic [DW-1:0]    wdata;
  } pend_t;
endpackage

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter; pointer advances past the winner.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt
);
  logic [1:0] ptr;
  logic [1:0] idx;
  logic [1:0] win;

  // first requester at or after the pointer wins
  always_comb begin
    gnt = '0;
    win = '0;
    idx = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
  end

  // pointer moves to the port after the winner
  always_ff @(posedge clk) begin
    if (rst)        ptr <= '0;
    else if (|gnt)  ptr <= win + 2'd1;
  end
endmodule

// File: rtl/lsu_bank_responder.sv
// Responding end of the four LSU ports: per-port pending entry,
// per-bank round-robin arbitration, 4-bank scratchpad, read/write responses.
module lsu_bank_responder
  import lsu_if_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int NBANK      = 4,
  parameter int BANK_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [R_Q-1:0]     R_request_0,
  input  logic [R_Q-1:0]     R_request_1,
  input  logic [R_Q-1:0]     R_request_2,
  input  logic [R_Q-1:0]     R_request_3,
  input  logic [W_Q-1:0]     W_request_0,
  input  logic [W_Q-1:0]     W_request_1,
  input  logic [W_Q-1:0]     W_request_2,
  input  logic [W_Q-1:0]     W_request_3,
  input  logic [A_bus-1:0]   LSU_addr_bus_0,
  input  logic [A_bus-1:0]   LSU_addr_bus_1,
  input  logic [A_bus-1:0]   LSU_addr_bus_2,
  input  logic [A_bus-1:0]   LSU_addr_bus_3,
  output logic [C_L_bus-1:0] CBG_to_LSU_bus_0,
  output logic [C_L_bus-1:0] CBG_to_LSU_bus_1,
  output logic [C_L_bus-1:0] CBG_to_LSU_bus_2,
  output logic [C_L_bus-1:0] CBG_to_LSU_bus_3
);
  logic [3:0]              r_req;
  logic [3:0][W_Q-1:0]     w_req;
  logic [3:0][ADDR_W-1:0]  addr;
  pend_t [3:0]             pend;
  logic [3:0]              bgnt [NBANK];
  logic [DATA_W-1:0]       bank_rd [NBANK];
  logic [3:0]              port_gnt;
  logic [3:0]              wack;
  logic [3:0]              rvalid;
  logic [1:0]              rbank [4];
  logic [DATA_W-1:0]       rhold [4];
  logic [DATA_W-1:0]       rdata [4];

  assign r_req = {R_request_3[0], R_request_2[0], R_request_1[0], R_request_0[0]};
  assign w_req = {W_request_3, W_request_2, W_request_1, W_request_0};
  assign addr  = {LSU_addr_bus_3, LSU_addr_bus_2, LSU_addr_bus_1, LSU_addr_bus_0};

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];
    logic [3:0]        req;
    logic [1:0]        sel;
    logic [DATA_W-1:0] rd_q;

    // pending ports that target this bank, and the granted one
    always_comb begin
      req = '0;
      sel = '0;
      for (int p = 0; p < 4; p++) begin
        req[p] = pend[p].valid && (pend[p].addr[1:0] == 2'(b));
        if (bgnt[b][p]) sel = 2'(p);
      end
    end

    rr_arbiter4 u_arb (.clk(clk), .rst(rst), .req(req), .gnt(bgnt[b]));

    // single-port bank: write or read at the grant edge
    always_ff @(posedge clk) begin
      if (!rst && (|bgnt[b])) begin
        if (pend[sel].we) mem[pend[sel].addr[ADDR_W-1:2]] <= pend[sel].wdata;
        else              rd_q <= mem[pend[sel].addr[ADDR_W-1:2]];
      end
    end

    assign bank_rd[b] = rd_q;
  end

  // a port is granted by at most one bank (the one its address selects)
  always_comb begin
    port_gnt = '0;
    for (int b = 0; b < NBANK; b++) port_gnt = port_gnt | bgnt[b];
  end

  // pending capture/clear, response strobes and rdata hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      wack   <= '0;
      rvalid <= '0;
      for (int p = 0; p < 4; p++) begin
        rbank[p] <= '0;
        rhold[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        wack[p]   <= port_gnt[p] &  pend[p].we;
        rvalid[p] <= port_gnt[p] & ~pend[p].we;
        if (port_gnt[p]) begin
          pend[p].valid <= 1'b0;
          rbank[p]      <= pend[p].addr[1:0];
        end else if (!pend[p].valid && (r_req[p] || w_req[p][WSTROBE])) begin
          pend[p].valid <= 1'b1;
          pend[p].we    <= w_req[p][WSTROBE];
          pend[p].addr  <= addr[p];
          pend[p].wdata <= w_req[p][DATA_W-1:0];
        end
        if (rvalid[p]) rhold[p] <= rdata[p];
      end
    end
  end

  // rdata shows the bank read during rvalid, otherwise the last value
  always_comb begin
    for (int p = 0; p < 4; p++) rdata[p] = rvalid[p] ? bank_rd[rbank[p]] : rhold[p];
  end

  assign CBG_to_LSU_bus_0 = {wack[0], rvalid[0], rdata[0]};
  assign CBG_to_LSU_bus_1 = {wack[1], rvalid[1], rdata[1]};
  assign CBG_to_LSU_bus_2 = {wack[2], rvalid[2], rdata[2]};
  assign CBG_to_LSU_bus_3 = {wack[3], rvalid[3], rdata[3]};
endmodule

// File: tb/tb_lsu_bank_responder.sv
// Bench for lsu_bank_responder: table of single-port transactions,
// directed contention/reset/protocol sequences, randomized traffic
// against a transaction-level reference model.
module tb_lsu_bank_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        r_req [4];
  logic [32:0] w_req [4];
  logic [9:0]  a     [4];
  wire  [33:0] bus   [4];

  always #5 clk = ~clk;

  lsu_bank_responder dut (
    .clk(clk), .rst(rst),
    .R_request_0(r_req[0]), .R_request_1(r_req[1]),
    .R_request_2(r_req[2]), .R_request_3(r_req[3]),
    .W_request_0(w_req[0]), .W_request_1(w_req[1]),
    .W_request_2(w_req[2]), .W_request_3(w_req[3]),
    .LSU_addr_bus_0(a[0]), .LSU_addr_bus_1(a[1]),
    .LSU_addr_bus_2(a[2]), .LSU_addr_bus_3(a[3]),
    .CBG_to_LSU_bus_0(bus[0]), .CBG_to_LSU_bus_1(bus[1]),
    .CBG_to_LSU_bus_2(bus[2]), .CBG_to_LSU_bus_3(bus[3])
  );

  // reference model state
  bit          pv  [4];
  bit          pwe [4];
  logic [9:0]  pa  [4];
  logic [31:0] pwd [4];
  int          ptr [4];
  logic [31:0] mem [1024];
  bit          ewa [4];
  bit          erv [4];
  logic [31:0] erd [4];

  int total = 0, bad = 0, perr = 0;
  int lat [4], nrv [4], nwa [4];

  typedef struct {
    int          port;
    bit          rd;
    bit          ws;
    logic [9:0]  addr;
    logic [31:0] wd;
    bit          exp_wack;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  task automatic clear_in();
    for (int p = 0; p < 4; p++) begin
      r_req[p] = 1'b0; w_req[p] = '0; a[p] = '0;
    end
  endtask

  // one clock edge worth of the spec rules, applied to the model
  task automatic model_edge();
    bit opv [4];
    bit gnt [4];
    bit strobe;
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        pv[p] = 0; ewa[p] = 0; erv[p] = 0; erd[p] = '0; ptr[p] = 0;
      end
      return;
    end
    for (int p = 0; p < 4; p++) begin opv[p] = pv[p]; gnt[p] = 0; end
    for (int b = 0; b < 4; b++) begin
      bit found = 0;
      for (int k = 0; k < 4; k++) begin
        int p = (ptr[b] + k) % 4;
        if (!found && opv[p] && int'(pa[p][1:0]) == b) begin
          found = 1; gnt[p] = 1; ptr[b] = (p + 1) % 4;
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      ewa[p] = gnt[p] && pwe[p];
      erv[p] = gnt[p] && !pwe[p];
      if (ewa[p]) mem[pa[p]] = pwd[p];
      if (erv[p]) erd[p] = mem[pa[p]];
      strobe = r_req[p] || w_req[p][32];
      if (opv[p] && strobe) perr++;
      if (gnt[p]) pv[p] = 0;
      else if (!opv[p] && strobe) begin
        pv[p] = 1; pwe[p] = w_req[p][32]; pa[p] = a[p]; pwd[p] = w_req[p][31:0];
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++)
      chk($sformatf("bus%0d", p), {30'd0, bus[p]}, {30'd0, ewa[p], erv[p], erd[p]});
  endtask

  // apply current inputs for one cycle, then idle; record response timing
  task automatic watch(input int n);
    for (int p = 0; p < 4; p++) begin lat[p] = 0; nrv[p] = 0; nwa[p] = 0; end
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) clear_in();
      for (int p = 0; p < 4; p++) begin
        if (bus[p][32]) nrv[p]++;
        if (bus[p][33]) nwa[p]++;
        if ((bus[p][32] || bus[p][33]) && lat[p] == 0) lat[p] = i;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int perr0;
    tbl[0] = '{0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b1, 32'h0};
    tbl[1] = '{0, 1'b1, 1'b0, 10'h005, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2] = '{1, 1'b1, 1'b1, 10'h07F, 32'h12345678, 1'b1, 32'h0};
    tbl[3] = '{2, 1'b1, 1'b0, 10'h07F, 32'h0,        1'b0, 32'h12345678};
    tbl[4] = '{3, 1'b0, 1'b1, 10'h3FF, 32'hA5A5A5A5, 1'b1, 32'h0};
    tbl[5] = '{3, 1'b1, 1'b0, 10'h3FF, 32'h0,        1'b0, 32'hA5A5A5A5};
    tbl[6] = '{1, 1'b0, 1'b1, 10'h200, 32'h0,        1'b1, 32'h0};
    tbl[7] = '{2, 1'b1, 1'b0, 10'h200, 32'h0,        1'b0, 32'h0};

    clear_in();
    rst = 1'b1;
    tick();
    chk("reset_bus", {bus[0][31:0], bus[1][31:0]} | {30'd0, bus[2][33:32], bus[3][33:32]}, 64'd0);
    rst = 1'b0;

    // preload addresses 0..31 so later reads are defined
    for (int i = 0; i < 32; i++) begin
      int p = i % 4;
      w_req[p] = {1'b1, 32'hC0DE0000 ^ (32'h01010101 * i)};
      a[p] = 10'(i);
      watch(2);
    end

    // single-port transactions
    for (int i = 0; i < 8; i++) begin
      int p = tbl[i].port;
      r_req[p] = tbl[i].rd;
      w_req[p] = {tbl[i].ws, tbl[i].wd};
      a[p]     = tbl[i].addr;
      watch(3);
      chk($sformatf("tbl%0d_lat", i), 64'(lat[p]), 64'd2);
      chk($sformatf("tbl%0d_wack", i), 64'(nwa[p]), 64'(tbl[i].exp_wack));
      chk($sformatf("tbl%0d_rvalid", i), 64'(nrv[p]), 64'(!tbl[i].exp_wack));
      if (!tbl[i].exp_wack)
        chk($sformatf("tbl%0d_rdata", i), 64'(bus[p][31:0]), 64'(tbl[i].exp_rd));
    end

    // four distinct banks in parallel
    for (int p = 0; p < 4; p++) begin r_req[p] = 1'b1; a[p] = 10'(p); end
    watch(4);
    for (int p = 0; p < 4; p++) chk($sformatf("par_lat%0d", p), 64'(lat[p]), 64'd2);

    // all four on bank 0 from a reset pointer, twice
    rst = 1'b1; tick(); rst = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < 4; p++) begin r_req[p] = 1'b1; a[p] = 10'(4 * (p + 1)); end
      watch(7);
      for (int p = 0; p < 4; p++)
        chk($sformatf("rr%0d_lat%0d", rep, p), 64'(lat[p]), 64'(2 + p));
    end

    // reset while port 2 waits behind other contenders
    for (int p = 0; p < 4; p++) begin r_req[p] = 1'b1; a[p] = 10'(4 * (p + 1)); end
    watch(2);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int p = 0; p < 4; p++) chk($sformatf("rst_bus%0d", p), 64'(bus[p]), 64'd0);
    watch(8);
    chk("rst_no_rv2", 64'(nrv[2]), 64'd0);
    chk("rst_no_rv_any", 64'(nrv[0] + nrv[1] + nrv[3]), 64'd0);
    r_req[0] = 1'b1; a[0] = 10'h005;
    watch(3);
    chk("rst_mem_kept", 64'(bus[0][31:0]), 64'hDEADBEEF);

    // second strobe while pending is ignored
    perr0 = perr;
    r_req[3] = 1'b1; a[3] = 10'h3FF;
    tick();
    a[3] = 10'h3FE;
    watch(7);
    chk("dup_one_resp", 64'(nrv[3]), 64'd1);
    chk("dup_rdata", 64'(bus[3][31:0]), 64'hA5A5A5A5);
    chk("dup_proto", 64'(perr - perr0), 64'd1);

    // randomized traffic on a small hot address range
    perr0 = perr;
    for (int c = 0; c < 600; c++) begin
      clear_in();
      for (int p = 0; p < 4; p++) begin
        if (!pv[p] && ($urandom % 2 == 1)) begin
          int kind = $urandom_range(0, 2);
          r_req[p] = (kind != 1);
          w_req[p] = {kind != 0, 32'($urandom)};
          a[p]     = 10'($urandom_range(0, 31));
        end
      end
      tick();
    end
    clear_in();
    for (int i = 0; i < 8; i++) tick();
    chk("rand_no_proto", 64'(perr - perr0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
